// File: rtl/versatile_fifo_sync_cmp_if.sv
// Handshake/status bundle between a FIFO user and versatile_fifo_sync_cmp.
// The overflow/underflow members exist only with VERSATILE_FIFO_SYNC_CMP_ERR_EN.
interface versatile_fifo_sync_cmp_if #(
    parameter int unsigned ADR_LENGTH = 6
);
    logic                  clear;
    logic                  wr;
    logic                  rd;
    logic [ADR_LENGTH-1:0] wadr;
    logic [ADR_LENGTH-1:0] radr;
    logic [ADR_LENGTH:0]   fill_level;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  almost_full;
    logic                  almost_empty;
`ifdef VERSATILE_FIFO_SYNC_CMP_ERR_EN
    logic                  overflow;
    logic                  underflow;
`endif

`ifdef VERSATILE_FIFO_SYNC_CMP_ERR_EN
    modport master (
        output clear, wr, rd,
        input  wadr, radr, fill_level, fifo_full, fifo_empty, almost_full, almost_empty,
        input  overflow, underflow
    );
    modport slave (
        input  clear, wr, rd,
        output wadr, radr, fill_level, fifo_full, fifo_empty, almost_full, almost_empty,
        output overflow, underflow
    );
`else
    modport master (
        output clear, wr, rd,
        input  wadr, radr, fill_level, fifo_full, fifo_empty, almost_full, almost_empty
    );
    modport slave (
        input  clear, wr, rd,
        output wadr, radr, fill_level, fifo_full, fifo_empty, almost_full, almost_empty
    );
`endif
endinterface

// File: rtl/versatile_fifo_sync_cmp.sv
// Single-clock FIFO pointer/flag controller for an external 2**ADR_LENGTH-entry RAM.
// Define VERSATILE_FIFO_SYNC_CMP_ERR_EN to add sticky overflow/underflow flags.
module versatile_fifo_sync_cmp #(
    parameter int unsigned ADR_LENGTH = 6,
    parameter int unsigned AF_MARGIN  = 2,
    parameter int unsigned AE_MARGIN  = 2
) (
    input logic                          clk,
    input logic                          rst_n,
    versatile_fifo_sync_cmp_if.slave     bus
);

    localparam int unsigned Depth = 1 << ADR_LENGTH;
    localparam logic [ADR_LENGTH:0] DepthLvl = (ADR_LENGTH+1)'(Depth);
    localparam logic [ADR_LENGTH:0] AfLvl    = (ADR_LENGTH+1)'(Depth - AF_MARGIN);
    localparam logic [ADR_LENGTH:0] AeLvl    = (ADR_LENGTH+1)'(AE_MARGIN);

    logic [ADR_LENGTH-1:0] wadr_q, wadr_d;
    logic [ADR_LENGTH-1:0] radr_q, radr_d;
    logic [ADR_LENGTH:0]   fill_q, fill_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  afull_q, afull_d;
    logic                  aempty_q, aempty_d;
    logic                  wr_ok, rd_ok;

    // A write into a full FIFO is allowed when a read frees a slot on the same edge.
    assign wr_ok = bus.wr & (~full_q | bus.rd);
    assign rd_ok = bus.rd & ~empty_q;

    always_comb begin
        wadr_d = wadr_q;
        radr_d = radr_q;
        fill_d = fill_q;
        if (bus.clear) begin
            wadr_d = '0;
            radr_d = '0;
            fill_d = '0;
        end else begin
            if (wr_ok) wadr_d = wadr_q + ADR_LENGTH'(1);
            if (rd_ok) radr_d = radr_q + ADR_LENGTH'(1);
            fill_d = fill_q + (ADR_LENGTH+1)'(wr_ok) - (ADR_LENGTH+1)'(rd_ok);
        end
        // Flags follow the next fill level so they land on the same edge as fill_level.
        full_d   = (fill_d == DepthLvl);
        empty_d  = (fill_d == '0);
        afull_d  = (fill_d >= AfLvl);
        aempty_d = (fill_d <= AeLvl);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wadr_q   <= '0;
            radr_q   <= '0;
            fill_q   <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            wadr_q   <= wadr_d;
            radr_q   <= radr_d;
            fill_q   <= fill_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
        end
    end

    assign bus.wadr         = wadr_q;
    assign bus.radr         = radr_q;
    assign bus.fill_level   = fill_q;
    assign bus.fifo_full    = full_q;
    assign bus.fifo_empty   = empty_q;
    assign bus.almost_full  = afull_q;
    assign bus.almost_empty = aempty_q;

`ifdef VERSATILE_FIFO_SYNC_CMP_ERR_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    always_comb begin
        ovf_d = ovf_q | (bus.wr & full_q & ~bus.rd);
        unf_d = unf_q | (bus.rd & empty_q);
        if (bus.clear) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
`endif

endmodule

// File: tb/tb_versatile_fifo_sync_cmp.sv
// Directed self-checking bench for versatile_fifo_sync_cmp (DEPTH=16, margins 2/2).
module tb_versatile_fifo_sync_cmp;

    localparam int unsigned AdrLength = 4;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    versatile_fifo_sync_cmp_if #(.ADR_LENGTH(AdrLength)) bus ();

    versatile_fifo_sync_cmp #(
        .ADR_LENGTH (AdrLength),
        .AF_MARGIN  (2),
        .AE_MARGIN  (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic w, input logic r, input logic c);
        bus.wr    = w;
        bus.rd    = r;
        bus.clear = c;
        @(posedge clk);
        #1;
        bus.wr    = 1'b0;
        bus.rd    = 1'b0;
        bus.clear = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, " wadr"}, 32'(bus.wadr), 0);
        check_eq({tag, " radr"}, 32'(bus.radr), 0);
        check_eq({tag, " fill"}, 32'(bus.fill_level), 0);
        check_eq({tag, " empty"}, 32'(bus.fifo_empty), 1);
        check_eq({tag, " full"}, 32'(bus.fifo_full), 0);
        check_eq({tag, " aempty"}, 32'(bus.almost_empty), 1);
        check_eq({tag, " afull"}, 32'(bus.almost_full), 0);
`ifdef VERSATILE_FIFO_SYNC_CMP_ERR_EN
        check_eq({tag, " overflow"}, 32'(bus.overflow), 0);
        check_eq({tag, " underflow"}, 32'(bus.underflow), 0);
`endif
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        bus.wr    = 1'b0;
        bus.rd    = 1'b0;
        bus.clear = 1'b0;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        check_reset_state("reset");

        // Fill to 16, checking almost flags at every level.
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 1'b0, 1'b0);
            check_eq($sformatf("fill w%0d", i), 32'(bus.fill_level), 32'(i));
            check_eq($sformatf("aempty w%0d", i), 32'(bus.almost_empty), (i <= 2) ? 1 : 0);
            check_eq($sformatf("afull w%0d", i), 32'(bus.almost_full), (i >= 14) ? 1 : 0);
        end
        check_eq("full after 16", 32'(bus.fifo_full), 1);
        check_eq("wadr after 16", 32'(bus.wadr), 0);
        check_eq("empty after 16", 32'(bus.fifo_empty), 0);

        step(1'b1, 1'b0, 1'b0);
        check_eq("wadr write-on-full", 32'(bus.wadr), 0);
        check_eq("fill write-on-full", 32'(bus.fill_level), 16);
`ifdef VERSATILE_FIFO_SYNC_CMP_ERR_EN
        check_eq("overflow", 32'(bus.overflow), 1);
`endif

        step(1'b1, 1'b1, 1'b0);
        check_eq("full wr&rd fill", 32'(bus.fill_level), 16);
        check_eq("full wr&rd full", 32'(bus.fifo_full), 1);
        check_eq("full wr&rd wadr", 32'(bus.wadr), 1);
        check_eq("full wr&rd radr", 32'(bus.radr), 1);

        step(1'b0, 1'b0, 1'b1);
        check_reset_state("clear from full");

        step(1'b0, 1'b1, 1'b0);
        check_eq("rd-on-empty radr", 32'(bus.radr), 0);
        check_eq("rd-on-empty fill", 32'(bus.fill_level), 0);
        check_eq("rd-on-empty empty", 32'(bus.fifo_empty), 1);
`ifdef VERSATILE_FIFO_SYNC_CMP_ERR_EN
        check_eq("underflow", 32'(bus.underflow), 1);
`endif
        step(1'b0, 1'b0, 1'b1);
        check_reset_state("clear after underflow");

        step(1'b1, 1'b1, 1'b0);
        check_eq("empty wr&rd fill", 32'(bus.fill_level), 1);
        check_eq("empty wr&rd empty", 32'(bus.fifo_empty), 0);
        check_eq("empty wr&rd wadr", 32'(bus.wadr), 1);
        check_eq("empty wr&rd radr", 32'(bus.radr), 0);
`ifdef VERSATILE_FIFO_SYNC_CMP_ERR_EN
        check_eq("empty wr&rd underflow", 32'(bus.underflow), 0);
`endif

        // 40 cycles: four rounds of 5 writes then 5 reads; both pointers wrap.
        for (int c = 0; c < 40; c++) begin
            step((c % 10) < 5, (c % 10) >= 5, 1'b0);
            check_eq($sformatf("invariant c%0d", c),
                     32'((bus.wadr - bus.radr) & 4'hf), 32'(bus.fill_level[3:0]));
        end
        check_eq("wrap wadr", 32'(bus.wadr), 5);
        check_eq("wrap radr", 32'(bus.radr), 4);
        check_eq("wrap fill", 32'(bus.fill_level), 1);

        repeat (3) step(1'b1, 1'b0, 1'b0);
        check_eq("pre-clear fill", 32'(bus.fill_level), 4);
        check_eq("pre-clear wadr", 32'(bus.wadr), 8);
        step(1'b1, 1'b1, 1'b1);
        check_reset_state("clear mid-stream");

        // Asynchronous reset mid-cycle, away from any clock edge.
        repeat (3) step(1'b1, 1'b0, 1'b0);
        check_eq("pre-rst fill", 32'(bus.fill_level), 3);
        #2 rst_n = 1'b0;
        #1;
        check_reset_state("async reset");
        #1 rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        check_reset_state("after reset release");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
